// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path: byte type, frame length,
// baud divisor and the transmit-arbiter state encoding.
package uart_pkg;

  typedef logic [7:0] byte_t;

  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  typedef enum logic {
    SRC_A,
    SRC_B
  } src_e;

  function automatic int baud_cnt_max(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small first-word-fall-through byte FIFO. A push into a full FIFO is dropped
// (even when a pop happens in the same cycle) and reported by a one-cycle ovf.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  byte_t din,
  input  logic  pop,
  output byte_t dout,
  output logic  empty,
  output logic  full,
  output logic  ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_ovf;
  byte_t         r_mem [DEPTH];

  logic          w_push_ok;
  logic          w_pop_ok;
  logic [AW:0]   w_count_next;

  // Full is judged on the registered flag, so a same-cycle pop never rescues a push.
  assign w_push_ok    = push & ~r_full;
  assign w_pop_ok     = pop & (r_count != '0);
  assign w_count_next = r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of the order the always blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == (AW+1)'(DEPTH));
      r_ovf   <= push & r_full;
    end
  end

  // NOTE: the storage array has no reset; the pointers and count define which
  // entries are valid, so clearing them alone discards any queued bytes.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign empty = (r_count == '0);
  assign full  = r_full;
  assign ovf   = r_ovf;

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx between the rx loopback (A) and the
// local message generator (B); it times each frame itself since uart_tx has no busy.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int UART_BPS   = 9600,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_BITS   = 1
) (
  input  logic  sys_clk,
  input  logic  sys_rst_n,
  input  byte_t a_data,
  input  logic  a_flag,
  input  byte_t b_data,
  input  logic  b_flag,
  output byte_t tx_data,
  output logic  tx_flag,
  output logic  a_full,
  output logic  b_full,
  output logic  a_ovf,
  output logic  b_ovf,
  output logic  busy
);

  localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
  localparam int FRAME_CYCLES = (FRAME_BITS + GAP_BITS) * BAUD_CNT_MAX;
  localparam int CW           = $clog2(FRAME_CYCLES);

  state_e        r_state;
  state_e        w_next_state;
  logic [CW-1:0] r_cnt;
  byte_t         r_tx_data;
  src_e          r_last_grant;

  logic          w_grant_valid;
  src_e          w_grant;
  logic          w_pop_a;
  logic          w_pop_b;
  logic          w_a_empty;
  logic          w_b_empty;
  byte_t         w_a_dout;
  byte_t         w_b_dout;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .push  (a_flag),
    .din   (a_data),
    .pop   (w_pop_a),
    .dout  (w_a_dout),
    .empty (w_a_empty),
    .full  (a_full),
    .ovf   (a_ovf)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .push  (b_flag),
    .din   (b_data),
    .pop   (w_pop_b),
    .dout  (w_b_dout),
    .empty (w_b_empty),
    .full  (b_full),
    .ovf   (b_ovf)
  );

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant       = SRC_A;
    if (!w_a_empty && !w_b_empty) begin
      w_grant_valid = 1'b1;
      w_grant       = (r_last_grant == SRC_A) ? SRC_B : SRC_A;
    end else if (!w_a_empty) begin
      w_grant_valid = 1'b1;
      w_grant       = SRC_A;
    end else if (!w_b_empty) begin
      w_grant_valid = 1'b1;
      w_grant       = SRC_B;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= IDLE;
    else            r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_grant_valid) w_next_state = ISSUE;
      ISSUE:   w_next_state = WAIT;
      WAIT:    if (r_cnt <= CW'(1)) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    tx_flag = (r_state == ISSUE);
    busy    = (r_state != IDLE);
    w_pop_a = (r_state == IDLE) && w_grant_valid && (w_grant == SRC_A);
    w_pop_b = (r_state == IDLE) && w_grant_valid && (w_grant == SRC_B);
  end

  // ISSUE plus FRAME_CYCLES-1 WAIT cycles plus one IDLE cycle spaces issues
  // exactly FRAME_CYCLES+1 apart under backlog.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt        <= '0;
      r_tx_data    <= '0;
      r_last_grant <= SRC_B;
    end else begin
      if (r_state == ISSUE)     r_cnt <= CW'(FRAME_CYCLES - 1);
      else if (r_state == WAIT) r_cnt <= r_cnt - CW'(1);
      if (w_pop_a || w_pop_b) begin
        r_tx_data    <= (w_grant == SRC_A) ? w_a_dout : w_b_dout;
        r_last_grant <= w_grant;
      end
    end
  end

  assign tx_data = r_tx_data;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: frame spacing 111 cycles at CLK_FREQ=1000,
// UART_BPS=100, GAP_BITS=1; issued bytes are logged with their cycle number.
module tb_uart_tx_arb;
  import uart_pkg::*;

  localparam int CLK_FREQ   = 1000;
  localparam int UART_BPS   = 100;
  localparam int FIFO_DEPTH = 4;
  localparam int GAP_BITS   = 1;
  localparam int SPACING    = 111;

  logic  sys_clk   = 1'b0;
  logic  sys_rst_n = 1'b0;
  byte_t a_data    = '0;
  logic  a_flag    = 1'b0;
  byte_t b_data    = '0;
  logic  b_flag    = 1'b0;
  byte_t tx_data;
  logic  tx_flag, a_full, b_full, a_ovf, b_ovf, busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  byte_t log_data[$];
  int    log_cyc[$];

  uart_tx_arb #(
    .CLK_FREQ   (CLK_FREQ),
    .UART_BPS   (UART_BPS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .GAP_BITS   (GAP_BITS)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .a_data    (a_data),
    .a_flag    (a_flag),
    .b_data    (b_data),
    .b_flag    (b_flag),
    .tx_data   (tx_data),
    .tx_flag   (tx_flag),
    .a_full    (a_full),
    .b_full    (b_full),
    .a_ovf     (a_ovf),
    .b_ovf     (b_ovf),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (tx_flag === 1'b1) begin
      log_data.push_back(tx_data);
      log_cyc.push_back(cyc);
    end
  end

  // Advance to just after the next rising edge; inputs are driven and outputs read there.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    a_flag = 1'b0; b_flag = 1'b0; a_data = '0; b_data = '0;
    repeat (3) step();
    sys_rst_n = 1'b1;
    step();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (2) step();
    n_checks++;
    if ({tx_flag, busy, a_ovf, b_ovf} !== 4'b0000)
      $display("FAIL reset_ctrl: got flag/busy/aovf/bovf=%b required 0000", {tx_flag, busy, a_ovf, b_ovf});
    else n_pass++;
    n_checks++;
    if ({a_full, b_full} !== 2'b00)
      $display("FAIL reset_full: got a_full/b_full=%b required 00", {a_full, b_full});
    else n_pass++;
    n_checks++;
    if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h required 00", tx_data);
    else n_pass++;
  endtask

  task automatic test_single();
    int t;
    do_reset();
    t = cyc;
    a_data = 8'h55; a_flag = 1'b1;
    step();
    a_flag = 1'b0;
    step();
    n_checks++;
    if ({tx_flag, busy} !== 2'b11 || tx_data !== 8'h55)
      $display("FAIL single_issue: got flag/busy=%b data=%h required 11 data=55", {tx_flag, busy}, tx_data);
    else n_pass++;
    wait_until(t + 111);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL single_busy_end: got busy=%b at t+111 required 1", busy);
    else n_pass++;
    step();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL single_idle: got busy=%b at t+112 required 0", busy);
    else n_pass++;
    n_checks++;
    if (tx_data !== 8'h55) $display("FAIL single_hold: got tx_data=%h required 55", tx_data);
    else n_pass++;
    wait_until(t + 300);
    n_checks++;
    if (log_data.size() != 1 || log_cyc[0] != t + 2)
      $display("FAIL single_count: got %0d pulses first at %0d required 1 at %0d",
               log_data.size(), (log_cyc.size() > 0) ? log_cyc[0] : -1, t + 2);
    else n_pass++;
  endtask

  task automatic test_tie();
    int t;
    byte_t exp_d [2] = '{8'h11, 8'h22};
    int    exp_c [2];
    do_reset();
    t = cyc;
    exp_c[0] = t + 2;
    exp_c[1] = t + 113;
    a_data = 8'h11; a_flag = 1'b1;
    b_data = 8'h22; b_flag = 1'b1;
    step();
    a_flag = 1'b0; b_flag = 1'b0;
    wait_until(t + 300);
    for (int i = 0; i < 2; i++) begin
      byte_t gd;
      int    gc;
      gd = (i < log_data.size()) ? log_data[i] : 8'hxx;
      gc = (i < log_cyc.size())  ? log_cyc[i]  : -1;
      n_checks++;
      if (gd !== exp_d[i] || gc != exp_c[i])
        $display("FAIL tie_%0d: got data=%h cyc=%0d required data=%h cyc=%0d", i, gd, gc, exp_d[i], exp_c[i]);
      else n_pass++;
    end
    n_checks++;
    if (log_data.size() != 2) $display("FAIL tie_count: got %0d pulses required 2", log_data.size());
    else n_pass++;
  endtask

  task automatic test_fairness();
    int t;
    byte_t exp_d [6] = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2};
    do_reset();
    t = cyc;
    for (int i = 0; i < 3; i++) begin
      a_data = 8'hA0 + 8'(i); a_flag = 1'b1;
      b_data = 8'hB0 + 8'(i); b_flag = 1'b1;
      step();
    end
    a_flag = 1'b0; b_flag = 1'b0;
    wait_until(t + 2 + SPACING * 6 + 20);
    for (int i = 0; i < 6; i++) begin
      byte_t gd;
      int    gc;
      gd = (i < log_data.size()) ? log_data[i] : 8'hxx;
      gc = (i < log_cyc.size())  ? log_cyc[i]  : -1;
      n_checks++;
      if (gd !== exp_d[i] || gc != t + 2 + SPACING * i)
        $display("FAIL fair_%0d: got data=%h cyc=%0d required data=%h cyc=%0d",
                 i, gd, gc, exp_d[i], t + 2 + SPACING * i);
      else n_pass++;
    end
    n_checks++;
    if (log_data.size() != 6) $display("FAIL fair_count: got %0d pulses required 6", log_data.size());
    else n_pass++;
  endtask

  task automatic test_overflow();
    int t;
    do_reset();
    t = cyc;
    for (int i = 0; i < 6; i++) begin
      a_data = 8'(i); a_flag = 1'b1;
      n_checks++;
      if (a_full !== (i == 5) || a_ovf !== 1'b0)
        $display("FAIL ovf_fill_%0d: got a_full=%b a_ovf=%b required a_full=%b a_ovf=0",
                 i, a_full, a_ovf, (i == 5));
      else n_pass++;
      step();
    end
    a_flag = 1'b0;
    n_checks++;
    if (a_ovf !== 1'b1) $display("FAIL ovf_pulse: got a_ovf=%b at t+6 required 1", a_ovf);
    else n_pass++;
    step();
    n_checks++;
    if (a_ovf !== 1'b0) $display("FAIL ovf_once: got a_ovf=%b at t+7 required 0", a_ovf);
    else n_pass++;
    wait_until(t + 2 + SPACING * 5 + 20);
    for (int i = 0; i < 5; i++) begin
      byte_t gd;
      int    gc;
      gd = (i < log_data.size()) ? log_data[i] : 8'hxx;
      gc = (i < log_cyc.size())  ? log_cyc[i]  : -1;
      n_checks++;
      if (gd !== 8'(i) || gc != t + 2 + SPACING * i)
        $display("FAIL ovf_order_%0d: got data=%h cyc=%0d required data=%h cyc=%0d",
                 i, gd, gc, 8'(i), t + 2 + SPACING * i);
      else n_pass++;
    end
    n_checks++;
    if (log_data.size() != 5) $display("FAIL ovf_count: got %0d pulses required 5", log_data.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int t;
    do_reset();
    t = cyc;
    for (int i = 0; i < 4; i++) begin
      a_data = 8'h70 + 8'(i); a_flag = 1'b1;
      b_data = 8'h90 + 8'(i); b_flag = 1'b1;
      step();
    end
    a_flag = 1'b0; b_flag = 1'b0;
    wait_until(t + 50);
    n_checks++;
    if ({busy, b_full} !== 2'b11) $display("FAIL mid_before: got busy/b_full=%b required 11", {busy, b_full});
    else n_pass++;
    #2 sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({tx_flag, busy, a_full, b_full} !== 4'b0000)
      $display("FAIL mid_async: got flag/busy/a_full/b_full=%b required 0000", {tx_flag, busy, a_full, b_full});
    else n_pass++;
    repeat (3) step();
    sys_rst_n = 1'b1;
    step();
    log_data.delete();
    log_cyc.delete();
    t = cyc;
    b_data = 8'h3C; b_flag = 1'b1;
    step();
    b_flag = 1'b0;
    wait_until(t + 300);
    n_checks++;
    if (log_data.size() != 1 || log_data[0] !== 8'h3C || log_cyc[0] != t + 2)
      $display("FAIL mid_after: got %0d pulses first data=%h cyc=%0d required 1 pulse data=3c cyc=%0d",
               log_data.size(), (log_data.size() > 0) ? log_data[0] : 8'hxx,
               (log_cyc.size() > 0) ? log_cyc[0] : -1, t + 2);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_fairness();
    test_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
Round-robin arbiter that shares one uart_tx serializer between two byte sources. Source A is the rx loopback (po_data/po_flag of uart_rx); source B is a local message/status generator.
Each source has its own small FIFO. The arbiter issues one pi_data/pi_flag pulse to uart_tx per frame. uart_tx has no busy output, so the arbiter times each frame itself and spaces issues a full frame apart.
It sits between uart_rx, the message generator and uart_tx inside the rs232 top level.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz.
UART_BPS, 9600, baud rate; must match uart_tx.
FIFO_DEPTH, 4, entries per source FIFO; power of two, at least 2.
GAP_BITS, 1, extra idle bit times inserted after each 10-bit frame.

Ports:
sys_clk  input  1  system clock
sys_rst_n  input  1  asynchronous active-low reset
a_data  input  8  source A byte
a_flag  input  1  source A push strobe, one cycle per byte
b_data  input  8  source B byte
b_flag  input  1  source B push strobe, one cycle per byte
tx_data  output  8  byte to uart_tx pi_data
tx_flag  output  1  one-cycle issue strobe to uart_tx pi_flag
a_full  output  1  source A FIFO full
b_full  output  1  source B FIFO full
a_ovf  output  1  one-cycle pulse: a source A byte was dropped
b_ovf  output  1  one-cycle pulse: a source B byte was dropped
busy  output  1  arbiter is in ISSUE or WAIT

Behaviour:
- Clock and reset: single clock, sys_clk. sys_rst_n is asynchronous, active-low.
- Reset values: tx_data=0, tx_flag=0, a_ovf=0, b_ovf=0, busy=0, both FIFOs empty, state=IDLE, last_grant=B (so A wins the first tie).
- Frame timing:
  - BAUD_CNT_MAX = CLK_FREQ/UART_BPS (integer division).
  - FRAME_CYCLES = (10+GAP_BITS)*BAUD_CNT_MAX.
  - Frame counter width = clog2(FRAME_CYCLES).
- FIFO push: on x_flag=1, push if the FIFO is not full at the start of the cycle.
  - If full, the byte is dropped even if a pop occurs in the same cycle.
  - A dropped byte produces x_ovf=1 on the following cycle only; FIFO contents are unchanged.
- x_full is registered and reflects the occupancy after the current edge.
- State machine:
  - IDLE: if neither FIFO is non-empty, stay in IDLE. If exactly one is non-empty, grant it. If both are non-empty, grant the source that is not last_grant.
    On a grant: pop that FIFO, load tx_data, update last_grant, go to ISSUE.
  - ISSUE: tx_flag=1 for exactly this cycle. Load the counter with FRAME_CYCLES-1. Go to WAIT.
  - WAIT: decrement the counter. When it reaches 0, go to IDLE.
- Spacing: tx_flag pulses are exactly FRAME_CYCLES+1 cycles apart under continuous backlog (ISSUE, FRAME_CYCLES-1 WAIT cycles, then IDLE).
- Latency: a byte pushed at cycle t into an empty FIFO while the arbiter is IDLE gives tx_flag high at t+2.
- tx_data holds its value from ISSUE until the next grant.
- Simultaneous pushes on both sources are both accepted; each FIFO is independent.
- Mid-operation reset clears all state immediately, including queued bytes; no stale byte is issued after release.
- busy=1 in ISSUE and WAIT, 0 in IDLE.

Decomposition:
- Package uart_pkg holds:
  - byte typedef (8 bits) and FRAME_BITS=10;
  - function baud_cnt_max(clk_freq, bps);
  - state enum {IDLE, ISSUE, WAIT}.
- Sub-module byte_fifo: synchronous FIFO with parameter DEPTH; ports push, din, pop, dout, empty, full, ovf. Instantiated twice.
- The arbiter FSM and frame counter live in uart_tx_arb.

Test Plan:
Bench parameters: CLK_FREQ=1000, UART_BPS=100, GAP_BITS=1, FIFO_DEPTH=4, giving FRAME_CYCLES=110 and issue spacing of 111 cycles.
1. Single byte: push A=0x55 at cycle t -> tx_flag at t+2 with tx_data=0x55; busy high t+2..t+111; no further pulses.
2. Tie after reset: A=0x11 and B=0x22 pushed at t -> 0x11 at t+2, 0x22 at t+113.
3. Fairness: A pushes 0xA0,0xA1,0xA2 and B pushes 0xB0,0xB1,0xB2 back-to-back -> issue order A0,B0,A1,B1,A2,B2, each 111 cycles apart.
4. Overflow: A pushes 0x00..0x05 on consecutive cycles t..t+5 ->
   - a_full=1 after edge t+4;
   - 0x05 dropped, a_ovf pulse at t+6 only;
   - 0x00..0x04 issued in order.
5. Reset mid-WAIT: with 3 bytes queued, assert sys_rst_n=0 mid-frame -> tx_flag, busy and full flags go 0 immediately. After release, push B=0x3C -> only 0x3C is issued, at +2.
